// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end
package fetch_pkg;
    typedef enum logic {FETCH, DRAIN} fetch_state_e;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;
    localparam int INST_BYTES = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; reads as zero when empty
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign do_pop = pop & !empty;
    // a pop frees the slot, so a full queue can still take a push in the same cycle
    assign do_push = push & (!full | do_pop);
    assign dout = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential PC generation, in-order return pairing and redirect handling
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int IQ_DEPTH = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_full,
    input  logic        ins_ready,
    input  logic [31:0] ins_value,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        dec_ready,
    output logic        new_ins,
    output logic [31:0] pc_addr,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QW = $clog2(IQ_DEPTH) + 1;
    localparam int PW = $clog2(MAX_OUTSTANDING) + 1;
    fetch_state_e state, state_nxt;
    logic [31:0] fetch_pc, pend_pc;
    logic [OW-1:0] outstanding, discard, out_nxt, disc_nxt;
    logic [QW-1:0] iq_count;
    logic [PW-1:0] pend_count;
    logic issue, ret, keep, pend_empty, pend_full, iq_empty, iq_full, unused_ok;
    fetch_entry_t iq_in, iq_head;
    assign ret = ins_ready & (discard != '0 | !pend_empty);
    assign keep = ins_ready & discard == '0 & !pend_empty & !redirect;
    assign iq_in = '{pc: pend_pc, inst: ins_value};
    assign inst_valid = !iq_empty;
    assign inst_data = iq_head.inst;
    assign inst_pc = iq_head.pc;
    assign unused_ok = ^{pend_count, iq_full};
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= FETCH;
        else
            state <= state_nxt;
    end
    // a redirect turns every fetch still in flight (and not returning now) into a discard
    always_comb begin
        out_nxt = outstanding + OW'(issue) - OW'(ret);
        disc_nxt = redirect ? out_nxt : discard - OW'(ins_ready & discard != '0);
        state_nxt = disc_nxt != '0 ? DRAIN : FETCH;
    end
    always_comb begin
        issue = state == FETCH & !redirect & !if_full & !pend_full
              & outstanding < OW'(MAX_OUTSTANDING)
              & (32'(iq_count) + 32'(outstanding) < 32'(IQ_DEPTH));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            new_ins <= 1'b0;
            pc_addr <= RESET_PC;
            outstanding <= '0;
            discard <= '0;
        end else begin
            fetch_pc <= redirect ? {redirect_pc[31:2], 2'b00}
                      : issue ? fetch_pc + 32'(INST_BYTES) : fetch_pc;
            new_ins <= issue;
            pc_addr <= issue ? fetch_pc : pc_addr;
            outstanding <= out_nxt;
            discard <= disc_nxt;
        end
    end
    fetch_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(32)) u_pend (
        .clk(clk), .rst(rst),
        .push(issue), .pop(ins_ready & discard == '0), .flush(redirect),
        .din(fetch_pc), .dout(pend_pc),
        .count(pend_count), .full(pend_full), .empty(pend_empty)
    );
    fetch_fifo #(.DEPTH(IQ_DEPTH), .WIDTH($bits(fetch_entry_t))) u_iq (
        .clk(clk), .rst(rst),
        .push(keep), .pop(inst_valid & dec_ready), .flush(redirect),
        .din(iq_in), .dout(iq_head),
        .count(iq_count), .full(iq_full), .empty(iq_empty)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench with a fixed-latency memory model for fetch_unit
module tb_fetch_unit;
    logic clk = 0, rst = 1, if_full = 0, ins_ready = 0, redirect = 0, dec_ready = 0;
    logic [31:0] ins_value = 0, redirect_pc = 0;
    logic new_ins, inst_valid;
    logic [31:0] pc_addr, inst_data, inst_pc;
    int n_chk = 0, n_pass = 0, cyc = 0, out_cnt = 0, max_out = 0;
    logic [31:0] mq[$], req_log[$], dec_log[$];
    int mt[$];

    fetch_unit #(.RESET_PC(32'h0), .IQ_DEPTH(4), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst(rst), .if_full(if_full), .ins_ready(ins_ready), .ins_value(ins_value),
        .redirect(redirect), .redirect_pc(redirect_pc), .dec_ready(dec_ready),
        .new_ins(new_ins), .pc_addr(pc_addr), .inst_valid(inst_valid),
        .inst_data(inst_data), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] pc);
        return pc * 32'd3 + 32'h1357_0001;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // one clock: log the decoder pop due at this edge, then run the 6-cycle memory model
    task automatic tick();
        if (inst_valid && dec_ready) begin
            check("dec_data", inst_data, word(inst_pc));
            dec_log.push_back(inst_pc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (ins_ready) out_cnt--;
        if (new_ins) begin
            req_log.push_back(pc_addr);
            mq.push_back(pc_addr);
            mt.push_back(cyc + 5);
            out_cnt++;
            if (out_cnt > max_out) max_out = out_cnt;
        end
        ins_ready = 0;
        if (mq.size() > 0 && mt[0] <= cyc) begin
            ins_ready = 1;
            ins_value = word(mq[0]);
            void'(mq.pop_front());
            void'(mt.pop_front());
        end
    endtask

    task automatic do_reset();
        rst = 1;
        ins_ready = 0;
        redirect = 0;
        if_full = 0;
        mq.delete();
        mt.delete();
        req_log.delete();
        dec_log.delete();
        out_cnt = 0;
        max_out = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        int n, bad, base, dbase;
        bit found;
        // reset values and streaming
        do_reset();
        check("rst_new_ins", 32'(new_ins), 0);
        check("rst_pc_addr", pc_addr, 32'h0);
        check("rst_inst_valid", 32'(inst_valid), 0);
        check("rst_inst_data", inst_data, 0);
        check("rst_inst_pc", inst_pc, 0);
        dec_ready = 1;
        repeat (40) tick();
        for (int i = 0; i < 4; i++) check("stream_req", req_log[i], 32'(4 * i));
        for (int i = 0; i < 4; i++) check("stream_dec", dec_log[i], 32'(4 * i));
        check("max_out", 32'(max_out), 4);
        // decoder stalled: credits run out at four
        do_reset();
        dec_ready = 0;
        repeat (30) tick();
        check("stall_nreq", 32'(req_log.size()), 4);
        check("stall_valid", 32'(inst_valid), 1);
        check("stall_head_pc", inst_pc, 32'h0);
        check("stall_head_data", inst_data, word(32'h0));
        dec_ready = 1;
        tick();
        dec_ready = 0;
        repeat (12) tick();
        check("pop_nreq", 32'(req_log.size()), 5);
        check("pop_req_pc", req_log[4], 32'h10);
        check("pop_dec_pc", dec_log[0], 32'h0);
        // if_full blocking
        do_reset();
        dec_ready = 1;
        repeat (10) tick();
        if_full = 1;
        n = 0;
        repeat (5) begin
            tick();
            n += 32'(new_ins);
        end
        if_full = 0;
        check("if_full_block", 32'(n), 0);
        base = req_log.size();
        repeat (40) tick();
        check("if_full_resume", 32'(req_log.size() > base + 4), 1);
        bad = 0;
        foreach (req_log[i]) if (req_log[i] != 32'(4 * i)) bad++;
        check("if_full_seq_req", 32'(bad), 0);
        bad = 0;
        foreach (dec_log[i]) if (dec_log[i] != 32'(4 * i)) bad++;
        check("if_full_seq_dec", 32'(bad), 0);
        // redirect with three in flight
        do_reset();
        dec_ready = 1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (req_log.size() == 3) found = 1;
            else tick();
        end
        check("redir3_found", 32'(found), 1);
        redirect = 1;
        redirect_pc = 32'h100;
        tick();
        redirect = 0;
        repeat (30) tick();
        check("redir3_nreq_before", 32'(req_log.size() > 3), 1);
        check("redir3_req", req_log[3], 32'h100);
        check("redir3_dec0", dec_log[0], 32'h100);
        check("redir3_dec1", dec_log[1], 32'h104);
        // redirect coincident with a return and a decoder pop
        do_reset();
        dec_ready = 1;
        repeat (8) tick();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (ins_ready && inst_valid) found = 1;
            else tick();
        end
        check("redir_coinc_found", 32'(found), 1);
        redirect = 1;
        redirect_pc = 32'h203;
        base = req_log.size();
        tick();
        redirect = 0;
        dbase = dec_log.size();
        repeat (40) tick();
        check("redir_coinc_req", req_log[base], 32'h200);
        for (int i = 0; i < 4; i++) check("redir_coinc_dec", dec_log[dbase + i], 32'h200 + 32'(4 * i));
        check("redir_coinc_max_out", 32'(max_out <= 4), 1);
        // async reset mid-burst
        do_reset();
        dec_ready = 1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (new_ins && inst_valid) found = 1;
            else tick();
        end
        check("arst_found", 32'(found), 1);
        #2;
        rst = 1;
        #1;
        check("arst_new_ins", 32'(new_ins), 0);
        check("arst_inst_valid", 32'(inst_valid), 0);
        check("arst_pc_addr", pc_addr, 32'h0);
        check("arst_inst_pc", inst_pc, 0);
        check("arst_inst_data", inst_data, 0);
        do_reset();
        repeat (20) tick();
        check("arst_req0", req_log[0], 32'h0);
        check("arst_req1", req_log[1], 32'h4);
        check("arst_dec0", dec_log[0], 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
